// File: rtl/rv32_wb_interconnect_if.sv
// Signal bundle between the RV32 core's peripheral port, the Wishbone
// interconnect and the peripheral slaves.
//   master : interconnect view (takes the core request, drives the bus)
//   slave  : environment view (core side plus the Wishbone slaves)
// Core side : mem_req_i, mem_we_i, mem_addr_i, mem_data_i -> mem_data_o,
//             stall_o, err_o
// Bus side  : wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
//             <- wb_ack_i, wb_err_i, wb_dat_i (per-slave, packed 32 bits each)
interface rv32_wb_interconnect_if #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 16
);
  logic                   mem_req_i;
  logic [3:0]             mem_we_i;
  logic [31:0]            mem_addr_i;
  logic [31:0]            mem_data_i;
  logic [31:0]            mem_data_o;
  logic                   stall_o;
  logic                   err_o;
  logic [ADDR_W-1:0]      wb_adr_o;
  logic [31:0]            wb_dat_o;
  logic                   wb_we_o;
  logic [3:0]             wb_sel_o;
  logic                   wb_stb_o;
  logic [N_SLAVES-1:0]    wb_cyc_o;
  logic [N_SLAVES-1:0]    wb_ack_i;
  logic [N_SLAVES-1:0]    wb_err_i;
  logic [N_SLAVES*32-1:0] wb_dat_i;

  modport master (
    input  mem_req_i, mem_we_i, mem_addr_i, mem_data_i,
    input  wb_ack_i, wb_err_i, wb_dat_i,
    output mem_data_o, stall_o, err_o,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );

  modport slave (
    output mem_req_i, mem_we_i, mem_addr_i, mem_data_i,
    output wb_ack_i, wb_err_i, wb_dat_i,
    input  mem_data_o, stall_o, err_o,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o
  );
endinterface

// File: rtl/rv32_wb_interconnect.sv
// Single-master, N-slave Wishbone B4 classic interconnect for the RV32 core's
// peripheral port. Decodes the core address against a base/mask table
// (lowest index wins on overlap), runs one registered bus cycle per request
// and stalls the core until the slave acks, errors or the bus times out.
// Decode misses complete immediately with an error.
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    rv32_wb_interconnect_if.master (core request/response + Wishbone)
module rv32_wb_interconnect #(
  parameter int unsigned            N_SLAVES   = 4,
  parameter int unsigned            ADDR_W     = 16,
  parameter logic [N_SLAVES*32-1:0] SLAVE_BASE = {32'h0000_3000, 32'h0000_2000,
                                                  32'h0000_1000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0] SLAVE_MASK = {N_SLAVES{32'hFFFF_F000}},
  parameter int unsigned            TIMEOUT    = 255
) (
  input logic                    clk_i,
  input logic                    rst_i,
  rv32_wb_interconnect_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q;
  logic [31:0]         dat_q;
  logic                we_q;
  logic [3:0]          sel_q;
  logic [N_SLAVES-1:0] cyc_sel_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                hit;
  logic [N_SLAVES-1:0] hit_sel;
  logic                sel_ack;
  logic                sel_err;
  logic [31:0]         sel_dat;
  logic                timeout_hit;

  // Address decode: first matching window in index order claims the access.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!hit && ((bus.mem_addr_i & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32])) begin
        hit        = 1'b1;
        hit_sel[i] = 1'b1;
      end
    end
  end

  // Responses are qualified by the latched select so other slaves are ignored.
  always_comb begin
    sel_dat = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (cyc_sel_q[i]) sel_dat = sel_dat | bus.wb_dat_i[i*32 +: 32];
    end
  end

  assign sel_ack     = |(bus.wb_ack_i & cyc_sel_q);
  assign sel_err     = |(bus.wb_err_i & cyc_sel_q);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    bus.stall_o     = 1'b0;
    bus.wb_stb_o    = 1'b0;
    bus.wb_cyc_o    = '0;
    bus.err_o       = 1'b0;
    bus.mem_data_o  = rdata_q;
    bus.wb_adr_o    = adr_q;
    bus.wb_dat_o    = dat_q;
    bus.wb_we_o     = we_q;
    bus.wb_sel_o    = sel_q;
    case (state_q)
      IDLE: begin
        bus.stall_o = bus.mem_req_i;
        if (bus.mem_req_i) state_d = hit ? BUSY : DONE;
      end
      BUSY: begin
        bus.stall_o  = 1'b1;
        bus.wb_stb_o = 1'b1;
        bus.wb_cyc_o = cyc_sel_q;
        if (sel_ack || sel_err || timeout_hit) state_d = DONE;
      end
      DONE: begin
        // The request still visible here is the one being retired.
        bus.err_o = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      cyc_sel_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.mem_req_i) begin
            cnt_q <= '0;
            if (hit) begin
              adr_q     <= bus.mem_addr_i[ADDR_W-1:0];
              dat_q     <= bus.mem_data_i;
              we_q      <= |bus.mem_we_i;
              sel_q     <= (|bus.mem_we_i) ? bus.mem_we_i : 4'hF;
              cyc_sel_q <= hit_sel;
            end else begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // Priority: slave error, then ack, then timeout.
          if (sel_err) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else if (sel_ack) begin
            err_q   <= 1'b0;
            rdata_q <= we_q ? '0 : sel_dat;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_wb_interconnect.sv
// Self-checking bench for rv32_wb_interconnect (default 4-slave map,
// TIMEOUT=8). The core and the slaves are modelled procedurally; expectations
// come from the address-map arithmetic and the response timing rules.
module tb_rv32_wb_interconnect;
  localparam int unsigned NS = 4;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  rv32_wb_interconnect_if #(.N_SLAVES(NS), .ADDR_W(16)) bus ();

  rv32_wb_interconnect #(
    .N_SLAVES  (NS),
    .ADDR_W    (16),
    .SLAVE_BASE({32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
    .SLAVE_MASK({NS{32'hFFFF_F000}}),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs for slaves other than the addressed one.
  logic          noise_en;
  logic [NS-1:0] force_ack;

  // Observations of the last access.
  int            obs_stall, obs_busy;
  logic          obs_hung, obs_unstable;
  logic [NS-1:0] obs_cyc_any, obs_done_cyc;
  logic [15:0]   obs_adr;
  logic [31:0]   obs_wdat, obs_done_dat, obs_after_dat;
  logic [3:0]    obs_sel;
  logic          obs_we, obs_done_err, obs_done_stb, obs_after_stb, obs_after_err;
  int unsigned   obs_start;

  // Map: slave i owns the 4 KiB page at i*0x1000, anything at/above 0x4000 misses.
  function automatic int ref_slave(input logic [31:0] a);
    if (a < 32'h4000) return int'(a >> 12);
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.mem_req_i  = 1'b0;
    bus.mem_we_i   = 4'h0;
    bus.mem_addr_i = 32'h0;
    bus.mem_data_i = 32'h0;
    bus.wb_ack_i   = '0;
    bus.wb_err_i   = '0;
    bus.wb_dat_i   = '0;
  endtask

  // Issue one core access at a negedge and play the slave side until the
  // core is released. kind: 0 ack, 1 err, 2 ack+err, 3 no response.
  // Returns at the negedge of the cycle after DONE with inputs cleared.
  task automatic run_access(input logic [31:0] addr, input logic [3:0] we,
                            input logic [31:0] wdata, input int wait_n,
                            input int kind, input logic [31:0] rdat);
    int            k = 0;
    int            it = 0;
    logic          done = 1'b0;
    logic          stb;
    logic [NS-1:0] cyc;
    obs_stall = 0; obs_busy = 0; obs_hung = 1'b1; obs_unstable = 1'b0;
    obs_cyc_any = '0; obs_done_cyc = '0; obs_done_dat = '0; obs_done_err = 1'b0;
    obs_done_stb = 1'b0; obs_adr = '0; obs_wdat = '0; obs_sel = '0; obs_we = 1'b0;
    obs_start = cycle_no;
    bus.mem_req_i  = 1'b1;
    bus.mem_we_i   = we;
    bus.mem_addr_i = addr;
    bus.mem_data_i = wdata;
    while (!done && it < 64) begin
      stb = bus.wb_stb_o;
      cyc = bus.wb_cyc_o;
      for (int unsigned s = 0; s < NS; s++) begin
        if (stb && cyc[s]) begin
          bus.wb_ack_i[s] = (k == wait_n) && (kind == 0 || kind == 2);
          bus.wb_err_i[s] = (k == wait_n) && (kind == 1 || kind == 2);
          bus.wb_dat_i[s*32 +: 32] = (k == wait_n) ? rdat : $urandom;
        end else begin
          bus.wb_ack_i[s] = noise_en ? 1'($urandom_range(0, 1)) : force_ack[s];
          bus.wb_err_i[s] = noise_en && ($urandom_range(0, 3) == 0);
          bus.wb_dat_i[s*32 +: 32] = $urandom;
        end
      end
      #1;
      if (bus.stall_o) begin
        obs_stall++;
        obs_cyc_any = obs_cyc_any | bus.wb_cyc_o;
        if (stb) begin
          if (obs_busy == 0) begin
            obs_adr = bus.wb_adr_o; obs_wdat = bus.wb_dat_o;
            obs_sel = bus.wb_sel_o; obs_we = bus.wb_we_o;
          end else if (bus.wb_adr_o !== obs_adr || bus.wb_dat_o !== obs_wdat ||
                       bus.wb_sel_o !== obs_sel || bus.wb_we_o !== obs_we || bus.wb_cyc_o !== cyc) begin
            obs_unstable = 1'b1;
          end
          obs_busy++;
          k++;
        end
      end else begin
        obs_done_err = bus.err_o;
        obs_done_dat = bus.mem_data_o;
        obs_done_cyc = bus.wb_cyc_o;
        obs_done_stb = bus.wb_stb_o;
        obs_hung     = 1'b0;
        done         = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      it++;
    end
    clear_inputs();
    #1;
    obs_after_stb = bus.wb_stb_o;
    obs_after_err = bus.err_o;
    obs_after_dat = bus.mem_data_o;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.wb_cyc_o !== '0) begin errors++; $display("FAIL rst_cyc: got %b expected 0", bus.wb_cyc_o); end
    checks++; if (bus.wb_stb_o !== 1'b0) begin errors++; $display("FAIL rst_stb: got %b expected 0", bus.wb_stb_o); end
    checks++; if (bus.wb_we_o !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", bus.wb_we_o); end
    checks++; if (bus.wb_sel_o !== 4'h0) begin errors++; $display("FAIL rst_sel: got %h expected 0", bus.wb_sel_o); end
    checks++; if (bus.wb_adr_o !== 16'h0) begin errors++; $display("FAIL rst_adr: got %h expected 0", bus.wb_adr_o); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h expected 0", bus.wb_dat_o); end
    checks++; if (bus.mem_data_o !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", bus.mem_data_o); end
    checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err_o); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", bus.stall_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_read_slave1();
    noise_en = 1'b0; force_ack = '0;
    run_access(32'h0000_1004, 4'h0, 32'h0, 0, 0, 32'hCAFE_BABE);
    checks++; if (obs_hung !== 1'b0) begin errors++; $display("FAIL rd1_done: never completed (bound expired)"); end
    checks++; if (obs_stall !== 2) begin errors++; $display("FAIL rd1_stall: got %0d cycles expected 2", obs_stall); end
    checks++; if (obs_cyc_any !== 4'b0010) begin errors++; $display("FAIL rd1_cyc: got %b expected 0010", obs_cyc_any); end
    checks++; if (obs_adr !== 16'h1004) begin errors++; $display("FAIL rd1_adr: got %h expected 1004", obs_adr); end
    checks++; if (obs_sel !== 4'hF || obs_we !== 1'b0) begin errors++; $display("FAIL rd1_sel_we: got sel %h we %b expected F 0", obs_sel, obs_we); end
    checks++; if (obs_done_dat !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd1_data: got %h expected cafebabe", obs_done_dat); end
    checks++; if (obs_done_err !== 1'b0) begin errors++; $display("FAIL rd1_err: got %b expected 0", obs_done_err); end
    checks++; if (obs_done_cyc !== '0 || obs_done_stb !== 1'b0) begin errors++; $display("FAIL rd1_done_bus: got cyc %b stb %b expected 0 0", obs_done_cyc, obs_done_stb); end
    checks++; if (obs_after_stb !== 1'b0) begin errors++; $display("FAIL rd1_no_reissue: got stb %b expected 0", obs_after_stb); end
    checks++; if (obs_after_dat !== 32'hCAFE_BABE) begin errors++; $display("FAIL rd1_hold: got %h expected cafebabe", obs_after_dat); end
  endtask

  task automatic test_byte_write();
    noise_en = 1'b0; force_ack = '0;
    run_access(32'h0000_3008, 4'b0100, 32'h00AB_0000, 3, 0, 32'hDEAD_BEEF);
    checks++; if (obs_stall !== 5) begin errors++; $display("FAIL wr_stall: got %0d cycles expected 5", obs_stall); end
    checks++; if (obs_we !== 1'b1 || obs_sel !== 4'b0100) begin errors++; $display("FAIL wr_we_sel: got we %b sel %b expected 1 0100", obs_we, obs_sel); end
    checks++; if (obs_wdat !== 32'h00AB_0000 || obs_adr !== 16'h3008) begin errors++; $display("FAIL wr_adr_dat: got %h %h expected 3008 00ab0000", obs_adr, obs_wdat); end
    checks++; if (obs_cyc_any !== 4'b1000) begin errors++; $display("FAIL wr_cyc: got %b expected 1000", obs_cyc_any); end
    checks++; if (obs_unstable !== 1'b0) begin errors++; $display("FAIL wr_stable: bus outputs changed during BUSY, got 1 expected 0"); end
    checks++; if (obs_done_err !== 1'b0 || obs_done_dat !== 32'h0) begin errors++; $display("FAIL wr_resp: got err %b data %h expected 0 0", obs_done_err, obs_done_dat); end
  endtask

  task automatic test_decode_miss();
    noise_en = 1'b0; force_ack = '0;
    run_access(32'h0000_8000, 4'h0, 32'h0, 0, 0, 32'h1234_5678);
    checks++; if (obs_stall !== 1) begin errors++; $display("FAIL miss_stall: got %0d cycles expected 1", obs_stall); end
    checks++; if (obs_cyc_any !== '0 || obs_busy !== 0) begin errors++; $display("FAIL miss_cyc: got cyc %b busy %0d expected 0 0", obs_cyc_any, obs_busy); end
    checks++; if (obs_done_err !== 1'b1 || obs_done_dat !== 32'h0) begin errors++; $display("FAIL miss_resp: got err %b data %h expected 1 0", obs_done_err, obs_done_dat); end
    checks++; if (obs_after_err !== 1'b0) begin errors++; $display("FAIL miss_err_pulse: got %b expected 0", obs_after_err); end
  endtask

  task automatic test_timeout();
    noise_en = 1'b0; force_ack = '0;
    run_access(32'h0000_2010, 4'h0, 32'h0, 0, 3, 32'h0);
    checks++; if (obs_busy !== TO || obs_stall !== TO + 1) begin errors++; $display("FAIL to_len: got busy %0d stall %0d expected %0d %0d", obs_busy, obs_stall, TO, TO + 1); end
    checks++; if (obs_cyc_any !== 4'b0100 || obs_done_cyc !== '0) begin errors++; $display("FAIL to_cyc: got %b/%b expected 0100/0000", obs_cyc_any, obs_done_cyc); end
    checks++; if (obs_done_err !== 1'b1 || obs_done_dat !== 32'h0) begin errors++; $display("FAIL to_resp: got err %b data %h expected 1 0", obs_done_err, obs_done_dat); end
    checks++; if (obs_after_err !== 1'b0) begin errors++; $display("FAIL to_err_pulse: got %b expected 0", obs_after_err); end
    // Ack on the last allowed BUSY cycle beats the timeout.
    run_access(32'h0000_2014, 4'h0, 32'h0, TO - 1, 0, 32'h5A5A_0F0F);
    checks++; if (obs_stall !== TO + 1 || obs_done_err !== 1'b0 || obs_done_dat !== 32'h5A5A_0F0F) begin errors++; $display("FAIL to_edge_ack: got stall %0d err %b data %h expected %0d 0 5a5a0f0f", obs_stall, obs_done_err, obs_done_dat, TO + 1); end
    run_access(32'h0000_2018, 4'h0, 32'h0, 0, 0, 32'h0BAD_CAFE);
    checks++; if (obs_stall !== 2 || obs_done_err !== 1'b0 || obs_done_dat !== 32'h0BAD_CAFE) begin errors++; $display("FAIL to_next: got stall %0d err %b data %h expected 2 0 0badcafe", obs_stall, obs_done_err, obs_done_dat); end
  endtask

  task automatic test_err_priority();
    noise_en = 1'b0; force_ack = 4'b0010;
    run_access(32'h0000_0040, 4'h0, 32'h0, 0, 2, 32'h1111_2222);
    force_ack = '0;
    checks++; if (obs_cyc_any !== 4'b0001 || obs_stall !== 2) begin errors++; $display("FAIL errp_cyc: got cyc %b stall %0d expected 0001 2", obs_cyc_any, obs_stall); end
    checks++; if (obs_done_err !== 1'b1 || obs_done_dat !== 32'h0) begin errors++; $display("FAIL errp_resp: got err %b data %h expected 1 0", obs_done_err, obs_done_dat); end
  endtask

  task automatic test_reset_mid_busy();
    noise_en = 1'b0; force_ack = '0;
    run_access(32'h0000_1100, 4'h0, 32'h0, 0, 0, 32'hA5A5_0001);
    checks++; if (obs_done_dat !== 32'hA5A5_0001) begin errors++; $display("FAIL rmb_pre: got %h expected a5a50001", obs_done_dat); end
    bus.mem_req_i  = 1'b1;
    bus.mem_addr_i = 32'h0000_1008;
    bus.mem_data_i = 32'h7777_7777;
    @(posedge clk); @(negedge clk);
    checks++; if (bus.wb_stb_o !== 1'b1) begin errors++; $display("FAIL rmb_busy: got stb %b expected 1", bus.wb_stb_o); end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    checks++; if (bus.wb_cyc_o !== '0 || bus.wb_stb_o !== 1'b0 || bus.stall_o !== 1'b0) begin errors++; $display("FAIL rmb_ctl: got cyc %b stb %b stall %b expected 0 0 0", bus.wb_cyc_o, bus.wb_stb_o, bus.stall_o); end
    checks++; if (bus.wb_adr_o !== 16'h0 || bus.wb_dat_o !== 32'h0 || bus.wb_sel_o !== 4'h0 || bus.wb_we_o !== 1'b0) begin errors++; $display("FAIL rmb_bus: got adr %h dat %h sel %h we %b expected all 0", bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o); end
    checks++; if (bus.mem_data_o !== 32'h0 || bus.err_o !== 1'b0) begin errors++; $display("FAIL rmb_resp: got data %h err %b expected 0 0", bus.mem_data_o, bus.err_o); end
    @(negedge clk);
    rst = 1'b0;
    bus.wb_ack_i[1] = 1'b1;
    bus.wb_dat_i[63:32] = 32'hBAD0_BAD0;
    @(posedge clk); @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (bus.stall_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.err_o !== 1'b0 || bus.mem_data_o !== 32'h0) begin errors++; $display("FAIL rmb_late_ack: got stall %b stb %b err %b data %h expected 0 0 0 0", bus.stall_o, bus.wb_stb_o, bus.err_o, bus.mem_data_o); end
    run_access(32'h0000_1008, 4'h0, 32'h0, 1, 0, 32'h600D_F00D);
    checks++; if (obs_stall !== 3 || obs_done_err !== 1'b0 || obs_done_dat !== 32'h600D_F00D) begin errors++; $display("FAIL rmb_fresh: got stall %0d err %b data %h expected 3 0 600df00d", obs_stall, obs_done_err, obs_done_dat); end
  endtask

  task automatic test_back_to_back();
    int unsigned prev;
    noise_en = 1'b0; force_ack = '0;
    run_access(32'h0000_0010, 4'h0, 32'h0, 0, 0, 32'h0000_0A01);
    prev = obs_start;
    for (int unsigned n = 0; n < 3; n++) begin
      run_access(32'h0000_1000 + (n << 12), 4'h0, 32'h0, 0, 0, 32'h0000_0B00 + n);
      checks++; if (obs_start - prev !== 3) begin errors++; $display("FAIL b2b_pitch[%0d]: got %0d cycles expected 3", n, obs_start - prev); end
      checks++; if (obs_done_dat !== 32'h0000_0B00 + n || obs_done_err !== 1'b0) begin errors++; $display("FAIL b2b_data[%0d]: got %h err %b expected %h 0", n, obs_done_dat, obs_done_err, 32'h0000_0B00 + n); end
      prev = obs_start;
    end
  endtask

  task automatic test_random();
    logic [31:0]   addr, wdata, rdat, exp_dat;
    logic [3:0]    we;
    logic [NS-1:0] exp_cyc;
    int            idx, kind, wait_n, exp_stall;
    logic          exp_err;
    noise_en = 1'b1; force_ack = '0;
    for (int unsigned n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 5);
      addr = (idx < 4) ? ((32'(idx) << 12) | ($urandom & 32'h0000_0FFF)) : $urandom;
      we = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      wdata = $urandom; rdat = $urandom;
      kind = $urandom_range(0, 3);
      wait_n = $urandom_range(0, TO - 1);
      idx = ref_slave(addr);
      exp_cyc = '0;
      if (idx < 0) begin
        exp_stall = 1; exp_err = 1'b1; exp_dat = 32'h0;
      end else begin
        exp_cyc[idx] = 1'b1;
        if (kind == 3) begin
          exp_stall = TO + 1; exp_err = 1'b1; exp_dat = 32'h0;
        end else begin
          exp_stall = wait_n + 2; exp_err = (kind != 0);
          exp_dat = (kind == 0 && we == 4'h0) ? rdat : 32'h0;
        end
      end
      run_access(addr, we, wdata, wait_n, kind, rdat);
      checks++; if (obs_hung !== 1'b0 || obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d (hung %b) expected %0d", n, obs_stall, obs_hung, exp_stall); end
      checks++; if (obs_cyc_any !== exp_cyc) begin errors++; $display("FAIL rnd_cyc[%0d]: got %b expected %b", n, obs_cyc_any, exp_cyc); end
      checks++; if (obs_done_err !== exp_err || obs_done_dat !== exp_dat) begin errors++; $display("FAIL rnd_resp[%0d]: got err %b data %h expected %b %h", n, obs_done_err, obs_done_dat, exp_err, exp_dat); end
      if (idx >= 0) begin
        checks++; if (obs_adr !== addr[15:0] || obs_wdat !== wdata || obs_we !== (we != 4'h0) || obs_sel !== ((we != 4'h0) ? we : 4'hF) || obs_unstable !== 1'b0) begin errors++; $display("FAIL rnd_bus[%0d]: got adr %h dat %h we %b sel %h unstable %b expected %h %h %b %h 0", n, obs_adr, obs_wdat, obs_we, obs_sel, obs_unstable, addr[15:0], wdata, we != 4'h0, (we != 4'h0) ? we : 4'hF); end
      end
    end
    noise_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    noise_en = 1'b0;
    force_ack = '0;
    clear_inputs();
    test_reset();
    test_read_slave1();
    test_byte_write();
    test_decode_miss();
    test_timeout();
    test_err_priority();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
